spi_reg_master: RTL and testbench
=================================

SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning SCLK half-period in clk_core cycles (legal range 2..255).
REQ-002 SHALL have parameter GAP, default 8, meaning minimum clk_core cycles of SS high between transactions (legal range 1..255).
REQ-003 SHALL have port clk_core  input  1  the single system clock; all logic in this domain.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request, sampled only in IDLE.
REQ-006 SHALL have port wr  input  1  1 = write transaction, 0 = read transaction; sampled with start.
REQ-007 SHALL have port addr  input  7  register address; sampled with start.
REQ-008 SHALL have port wr_data  input  8  write data byte; sampled with start.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-011 SHALL have port rd_data  output  8  byte captured in the second byte slot; valid when done is high, held until the next done.
REQ-012 SHALL have port sclk  output  1  SPI clock.
REQ-013 SHALL have port mosi  output  1  SPI master-out.
REQ-014 SHALL have port miso  input  1  SPI master-in; synchronised with 2 flops before use.
REQ-015 SHALL have port ss  output  1  active-low slave select.

Function
REQ-016 SHALL implement SPI mode 0, MSB first: sclk idles low, mosi is updated only while sclk is low, miso is sampled on the sclk rising edge.
REQ-017 SHALL send exactly 16 bits per transaction: byte0 = {wr, addr[6:0]}, byte1 = wr_data for writes and 8'h00 for reads.
REQ-018 SHALL capture the 8 bits sampled during byte1 into rd_data for both reads and writes.
REQ-019 SHALL use states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, with transitions as follows:
  - IDLE: on start, latch inputs, drive ss low, drive bit15 on mosi, go to SETUP.
  - SETUP: after CLK_DIV cycles, go to SHIFT.
  - SHIFT: run 16 sclk periods of 2*CLK_DIV cycles each; after the 16th falling edge, go to HOLD.
  - HOLD: after CLK_DIV cycles, raise ss, pulse done, go to GAP.
  - GAP: after GAP cycles, go to IDLE.
REQ-020 SHALL keep ss low for exactly 34*CLK_DIV clk_core cycles per transaction.
REQ-021 SHALL ignore start while busy is high, including during GAP; the ignored request is dropped, not queued.
REQ-022 SHALL hold busy high through GAP; busy SHALL fall in the same cycle the state returns to IDLE.
REQ-023 SHALL accept a new start in the first IDLE cycle, so back-to-back transactions are separated by exactly GAP cycles of ss high.
REQ-024 SHALL change wr, addr and wr_data internally only at start acceptance; input changes mid-transaction SHALL have no effect on the transfer.

Reset
REQ-025 SHALL, on reset_n low, immediately force: state = IDLE, sclk = 0, ss = 1, mosi = 0, busy = 0, done = 0, rd_data = 8'h00, error = 0.
REQ-026 SHALL, on reset asserted mid-transaction, abort the transfer with ss high within the same asynchronous assertion, and SHALL produce no done pulse.
REQ-027 SHALL release reset without any sclk edge or ss glitch.

Configuration
REQ-028 SHALL, when macro SPI_REG_MASTER_VERIFY_EN is defined:
  - follow every write with an automatic read of the same address after GAP; busy stays high throughout;
  - pulse done once, at the end of the readback;
  - set output error (1 bit) high with that done if rd_data != wr_data, and clear it on the next start.
REQ-029 SHALL, when SPI_REG_MASTER_VERIFY_EN is undefined, perform single-transaction writes, omit the readback, and tie error to 0.

Verification
REQ-030 Read of version: start, wr=0, addr=0x00, slave model returns 0xC2 -> mosi bits 0x00,0x00; done after 34*4+1 cycles; rd_data=0xC2.
REQ-031 Write of bootloader register: wr=1, addr=0x01, wr_data=0x01 -> mosi 0x81,0x01; ss low exactly 136 cycles; 16 rising sclk edges.
REQ-032 Back-to-back: start asserted each cycle continuously -> transactions separated by exactly GAP=8 ss-high cycles; one done per transaction.
REQ-033 Reset mid-transaction: assert reset_n low after the 5th rising sclk edge -> ss=1, sclk=0 immediately; no done; next read returns correct data.
REQ-034 Verify mode (macro defined): write 0xA5 to 0x01, slave returns 0x01 -> two ss frames, single done, error=1; repeat with slave echoing 0xA5 -> error=0.
REQ-035 CLK_DIV=2: read of 0x00 -> sclk period 4 cycles, rd_data=0xC2, miso sampled correctly through the 2-flop synchroniser.

Source files
------------

// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - SPI mode-0 register master, 16-bit {wr,addr,data} frames.
// Define SPI_REG_MASTER_VERIFY_EN to follow each write with an automatic readback compare.
module spi_reg_master #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic       clk_core,
    input  logic       reset_n,
    input  logic       start,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       ss,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] DIV_LAST      = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST      = 8'(GAP - 1);
    // The IDLE cycle that accepts the next start is part of the ss-high gap.
    localparam logic [7:0] GAP_LAST_IDLE = (GAP > 1) ? 8'(GAP - 2) : 8'd0;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic        cnt_last;
    logic [4:0]  edge_cnt;
    logic [15:0] tx_sr;
    logic [7:0]  rx_sr;
    logic        miso_s1;
    logic        miso_s2;
    logic [1:0]  rise_d;
    logic        rise_now;
    logic        shift_end;
    logic        rb_pend;

`ifdef SPI_REG_MASTER_VERIFY_EN
    logic       rb_q;
    logic       rb_chk;
    logic       err_q;
    logic [6:0] addr_q;
    logic [7:0] wdata_q;

    assign rb_pend = rb_q;
    assign error   = err_q;
`else
    assign rb_pend = 1'b0;
    assign error   = 1'b0;
`endif

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        cnt_last = 1'b0;
        case (state)
            S_SETUP, S_SHIFT, S_HOLD: cnt_last = (cnt == DIV_LAST);
            S_GAP:                    cnt_last = rb_pend ? (cnt == GAP_LAST) : (cnt == GAP_LAST_IDLE);
            default:                  cnt_last = 1'b0;
        endcase
        rise_now  = (state == S_SHIFT) && cnt_last && !sclk;
        shift_end = (state == S_SHIFT) && cnt_last && (edge_cnt == 5'd31);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start)     state_nx = S_SETUP;
            S_SETUP: if (cnt_last)  state_nx = S_SHIFT;
            S_SHIFT: if (shift_end) state_nx = S_HOLD;
            S_HOLD:  if (cnt_last)  state_nx = (GAP == 1 && !rb_pend) ? S_IDLE : S_GAP;
            S_GAP:   if (cnt_last)  state_nx = rb_pend ? S_SETUP : S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        mosi = tx_sr[15];
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= 8'd0;
            edge_cnt <= 5'd0;
            tx_sr    <= 16'h0000;
            rx_sr    <= 8'h00;
            miso_s1  <= 1'b0;
            miso_s2  <= 1'b0;
            rise_d   <= 2'b00;
            sclk     <= 1'b0;
            ss       <= 1'b1;
            done     <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
            // Sample two cycles after the rising edge so the synchroniser holds the bit present at that edge.
            rise_d  <= {rise_d[0], rise_now};
            done    <= 1'b0;
            if (rise_d[1]) begin
                rx_sr <= {rx_sr[6:0], miso_s2};
            end
            cnt <= (state == S_IDLE || cnt_last) ? 8'd0 : cnt + 8'd1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ss       <= 1'b0;
                        tx_sr    <= {wr, addr, (wr ? wr_data : 8'h00)};
                        edge_cnt <= 5'd0;
                    end
                end
                S_SHIFT: begin
                    if (cnt_last) begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 5'd1;
                        if (sclk) begin
                            tx_sr <= {tx_sr[14:0], 1'b0};
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt_last) begin
                        ss <= 1'b1;
                        if (!rb_pend) begin
                            done    <= 1'b1;
                            rd_data <= rx_sr;
                        end
                    end
                end
                S_GAP: begin
`ifdef SPI_REG_MASTER_VERIFY_EN
                    if (cnt_last && rb_pend) begin
                        ss       <= 1'b0;
                        tx_sr    <= {1'b0, addr_q, 8'h00};
                        edge_cnt <= 5'd0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SPI_REG_MASTER_VERIFY_EN
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            rb_q    <= 1'b0;
            rb_chk  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 7'h00;
            wdata_q <= 8'h00;
        end else if (state == S_IDLE && start) begin
            rb_q    <= wr;
            rb_chk  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= addr;
            wdata_q <= wr_data;
        end else if (state == S_GAP && cnt_last && rb_q) begin
            rb_q   <= 1'b0;
            rb_chk <= 1'b1;
        end else if (state == S_HOLD && cnt_last && !rb_q) begin
            err_q <= rb_chk && (rx_sr != wdata_q);
        end
    end
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// tb/tb_spi_reg_master.sv - directed bench for spi_reg_master with mode-0 slave models.
`timescale 1ns/1ps
module tb_spi_reg_master;
    localparam int CP = 10;

    logic clk_core = 1'b0;
    always #(CP/2) clk_core = ~clk_core;

    logic       reset_n;
    logic       start0, wr0, busy0, done0, sclk0, mosi0, miso0, ss0, error0;
    logic [6:0] addr0;
    logic [7:0] wdata0, rd0;
    logic       start1, wr1, busy1, done1, sclk1, mosi1, miso1, ss1, error1;
    logic [6:0] addr1;
    logic [7:0] wdata1, rd1;

    spi_reg_master #(.CLK_DIV(4), .GAP(8)) dut (
        .clk_core(clk_core), .reset_n(reset_n), .start(start0), .wr(wr0), .addr(addr0),
        .wr_data(wdata0), .busy(busy0), .done(done0), .rd_data(rd0), .sclk(sclk0),
        .mosi(mosi0), .miso(miso0), .ss(ss0), .error(error0));

    spi_reg_master #(.CLK_DIV(2), .GAP(8)) dut_div2 (
        .clk_core(clk_core), .reset_n(reset_n), .start(start1), .wr(wr1), .addr(addr1),
        .wr_data(wdata1), .busy(busy1), .done(done1), .rd_data(rd1), .sclk(sclk1),
        .mosi(mosi1), .miso(miso1), .ss(ss1), .error(error1));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mode-0 slaves: miso shifts on sclk falling edges, mosi captured on rising edges.
    logic [7:0]  resp0, resp1;
    logic [15:0] word0, word1, s_in0, s_in1;
    int          rise0, rises_last0, fall0, rise1, fall1;
    time         rt_a1, rt_b1;

    assign word0 = {8'h00, resp0};
    assign word1 = {8'h00, resp1};
    assign miso0 = (ss0 || fall0 > 15) ? 1'b0 : word0[4'(15 - fall0)];
    assign miso1 = (ss1 || fall1 > 15) ? 1'b0 : word1[4'(15 - fall1)];

    always @(posedge sclk0 or posedge ss0) begin
        if (ss0) begin
            rises_last0 = rise0;
            rise0 = 0;
        end else begin
            s_in0 = {s_in0[14:0], mosi0};
            rise0++;
        end
    end
    always @(negedge sclk0 or posedge ss0) begin
        if (ss0) fall0 = 0;
        else     fall0++;
    end
    always @(posedge sclk1 or posedge ss1) begin
        if (ss1) begin
            rise1 = 0;
        end else begin
            s_in1 = {s_in1[14:0], mosi1};
            rise1++;
            rt_a1 = rt_b1;
            rt_b1 = $time;
        end
    end
    always @(negedge sclk1 or posedge ss1) begin
        if (ss1) fall1 = 0;
        else     fall1++;
    end

    // Frame monitor for the CLK_DIV=4 instance.
    int   lo_run, hi_run, last_low, last_gap, frames, dones;
    logic clr_mon;
    always @(negedge clk_core) begin
        if (clr_mon) begin
            lo_run = 0; hi_run = 0; last_low = 0; last_gap = 0; frames = 0; dones = 0;
        end else begin
            if (!ss0) begin
                if (lo_run == 0) begin
                    if (frames > 0) last_gap = hi_run;
                    hi_run = 0;
                end
                lo_run++;
            end else begin
                if (lo_run > 0) begin
                    last_low = lo_run;
                    frames++;
                    lo_run = 0;
                end
                hi_run++;
            end
            if (done0) dones++;
        end
    end

    task automatic clear_mon();
        clr_mon = 1'b1;
        @(negedge clk_core);
        #1 clr_mon = 1'b0;
    endtask

    task automatic run0(input logic w, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] r, output int lat);
        resp0 = r;
        @(negedge clk_core);
        wr0 = w; addr0 = a; wdata0 = d; start0 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk_core);
            start0 = 1'b0;
            lat++;
        end while (!done0 && lat < 3000);
        if (!done0) check("done_timeout", 32'(done0), 32'd1);
    endtask

    int lat, n;

    initial begin
        reset_n = 1'b0; clr_mon = 1'b1;
        start0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0; resp0 = 0; s_in0 = 0;
        start1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0; resp1 = 0; s_in1 = 0;
        rt_a1 = 0; rt_b1 = 0;
        repeat (3) @(negedge clk_core);
        check("rst_ss", 32'(ss0), 32'd1);
        check("rst_sclk", 32'(sclk0), 32'd0);
        check("rst_mosi", 32'(mosi0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_rd_data", 32'(rd0), 32'd0);
        check("rst_error", 32'(error0), 32'd0);
        reset_n = 1'b1;
        clear_mon();
        repeat (5) @(negedge clk_core);
        check("release_ss", 32'(ss0), 32'd1);
        check("release_sclk", 32'(sclk0), 32'd0);

        // Version read.
        run0(1'b0, 7'h00, 8'h00, 8'hC2, lat);
        check("rd_latency", 32'(lat), 32'd137);
        check("rd_data_c2", 32'(rd0), 32'hC2);
        check("rd_mosi", 32'(s_in0), 32'h0000);
        check("rd_rises", 32'(rises_last0), 32'd16);
        check("rd_busy_in_gap", 32'(busy0), 32'd1);
        repeat (10) @(negedge clk_core);
        check("rd_ss_low", 32'(last_low), 32'd136);
        check("rd_dones", 32'(dones), 32'd1);
        check("rd_busy_idle", 32'(busy0), 32'd0);

`ifndef SPI_REG_MASTER_VERIFY_EN
        clear_mon();
        run0(1'b1, 7'h01, 8'h01, 8'h5A, lat);
        check("wr_latency", 32'(lat), 32'd137);
        check("wr_mosi", 32'(s_in0), 32'h8101);
        check("wr_rd_data", 32'(rd0), 32'h5A);
        check("wr_rises", 32'(rises_last0), 32'd16);
        repeat (10) @(negedge clk_core);
        check("wr_ss_low", 32'(last_low), 32'd136);
        check("wr_frames", 32'(frames), 32'd1);
`else
        clear_mon();
        run0(1'b1, 7'h01, 8'hA5, 8'h01, lat);
        check("vfy_error_set", 32'(error0), 32'd1);
        check("vfy_rd_data", 32'(rd0), 32'h01);
        repeat (10) @(negedge clk_core);
        check("vfy_frames", 32'(frames), 32'd2);
        check("vfy_dones", 32'(dones), 32'd1);
        check("vfy_gap", 32'(last_gap), 32'd8);
        run0(1'b1, 7'h01, 8'hA5, 8'hA5, lat);
        check("vfy_error_clr", 32'(error0), 32'd0);
        repeat (10) @(negedge clk_core);
`endif

        // Inputs changed after acceptance, then a start pulse during GAP that must be dropped.
        clear_mon();
        resp0 = 8'h7E;
        @(negedge clk_core);
        wr0 = 1'b0; addr0 = 7'h12; wdata0 = 8'h00; start0 = 1'b1;
        @(negedge clk_core);
        start0 = 1'b0; wr0 = 1'b1; addr0 = 7'h55; wdata0 = 8'hFF;
        n = 0;
        while (!done0 && n < 500) begin @(negedge clk_core); n++; end
        check("chg_mosi", 32'(s_in0), 32'h1200);
        check("chg_rd_data", 32'(rd0), 32'h7E);
        @(negedge clk_core);
        start0 = 1'b1; wr0 = 1'b0; addr0 = 7'h00;
        @(negedge clk_core);
        start0 = 1'b0;
        repeat (30) @(negedge clk_core);
        check("gap_start_frames", 32'(frames), 32'd1);
        check("gap_start_dones", 32'(dones), 32'd1);

        // Back-to-back with start held high.
        clear_mon();
        resp0 = 8'h3C;
        @(negedge clk_core);
        wr0 = 1'b0; addr0 = 7'h05; start0 = 1'b1;
        n = 0;
        do begin @(negedge clk_core); #1; n++; end while (dones < 3 && n < 2000);
        start0 = 1'b0;
        repeat (30) @(negedge clk_core);
        check("b2b_dones", 32'(dones), 32'd3);
        check("b2b_frames", 32'(frames), 32'd3);
        check("b2b_gap", 32'(last_gap), 32'd8);
        check("b2b_ss_low", 32'(last_low), 32'd136);
        check("b2b_rd_data", 32'(rd0), 32'h3C);
        check("b2b_mosi", 32'(s_in0), 32'h0500);

        // Reset after the 5th rising sclk edge.
        clear_mon();
        resp0 = 8'hC2;
        @(negedge clk_core);
        wr0 = 1'b0; addr0 = 7'h00; start0 = 1'b1;
        @(negedge clk_core);
        start0 = 1'b0;
        n = 0;
        while (rise0 < 5 && n < 500) begin @(negedge clk_core); n++; end
        check("abort_reached_5", 32'(rise0), 32'd5);
        #2 reset_n = 1'b0;
        #1;
        check("abort_ss", 32'(ss0), 32'd1);
        check("abort_sclk", 32'(sclk0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        repeat (20) @(negedge clk_core);
        check("abort_no_done", 32'(dones), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_core);
        run0(1'b0, 7'h00, 8'h00, 8'hC2, lat);
        check("post_abort_rd", 32'(rd0), 32'hC2);
        check("post_abort_mosi", 32'(s_in0), 32'h0000);
        check("post_abort_lat", 32'(lat), 32'd137);

        // CLK_DIV=2 instance.
        resp1 = 8'hC2;
        @(negedge clk_core);
        wr1 = 1'b0; addr1 = 7'h00; start1 = 1'b1;
        lat = 0;
        do begin @(negedge clk_core); start1 = 1'b0; lat++; end while (!done1 && lat < 1000);
        check("div2_latency", 32'(lat), 32'd69);
        check("div2_rd_data", 32'(rd1), 32'hC2);
        check("div2_mosi", 32'(s_in1), 32'h0000);
        check("div2_sclk_period", 32'(rt_b1 - rt_a1), 32'(4 * CP));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
